mem_scheduler: RTL and testbench

MEM_SCHEDULER -- requirements
Module: mem_scheduler

---
 rtl/mem_scheduler.sv | 120 ++++++++++++
 tb/tb_mem_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_scheduler.sv
// Round-robin memory access scheduler: grants one core at a time, supports locked bursts
// and multi-cycle device-space accesses.
module mem_scheduler #(
  parameter int unsigned NUM_REQ     = 8,
  parameter int unsigned LOCK_MAX    = 4,
  parameter int unsigned DEVICE_WAIT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         request,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic                       device_sel,
  output logic [NUM_REQ-1:0]         grant_oh,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         ack_oh,
  output logic                       busy
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned BurstW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam int unsigned WaitW  = (DEVICE_WAIT > 0) ? $clog2(DEVICE_WAIT + 1) : 1;
  localparam bit          HasWait = (DEVICE_WAIT > 0);

  localparam logic [BurstW-1:0] BurstLast = BurstW'(LOCK_MAX - 1);
  localparam logic [WaitW-1:0]  WaitLoad  = WaitW'(DEVICE_WAIT);

  typedef enum logic [1:0] {StIdle, StGrant, StDevWait} state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_oh_q;
  logic [IdW-1:0]      grant_id_q;
  logic [IdW-1:0]      ptr_q;
  logic [BurstW-1:0]   burst_q;
  logic [WaitW-1:0]    wait_q;

  logic                any_req;
  logic [IdW-1:0]      win_id;
  logic [IdW-1:0]      cand;
  logic [NUM_REQ-1:0]  win_oh;
  logic [IdW-1:0]      ptr_next;
  logic                req_g;
  logic                lock_g;
  logic                complete;
  logic                abandon;
  logic                keep;
  logic                rearb;

  // ptr_q holds the highest-priority index, i.e. one past the last granted core.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_req && request[cand]) begin
        any_req = 1'b1;
        win_id  = cand;
      end
    end
    win_oh         = '0;
    win_oh[win_id] = any_req;
    ptr_next       = (win_id == IdW'(NUM_REQ - 1)) ? '0 : win_id + IdW'(1);
  end

  assign req_g  = request[grant_id_q];
  assign lock_g = lock[grant_id_q];

  always_comb begin
    complete = 1'b0;
    unique case (state_q)
      StGrant:   complete = req_g && !(device_sel && HasWait);
      StDevWait: complete = req_g && (wait_q == WaitW'(1));
      default:   complete = 1'b0;
    endcase
  end

  assign abandon = (state_q != StIdle) && !req_g;
  assign keep    = complete && lock_g && (burst_q < BurstLast);
  assign rearb   = (state_q == StIdle) || abandon || (complete && !keep);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_oh_q <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      burst_q    <= '0;
      wait_q     <= '0;
    end else if (rearb) begin
      burst_q <= '0;
      wait_q  <= '0;
      if (any_req) begin
        state_q    <= StGrant;
        grant_oh_q <= win_oh;
        grant_id_q <= win_id;
        ptr_q      <= ptr_next;
      end else begin
        state_q    <= StIdle;
        grant_oh_q <= '0;
        grant_id_q <= '0;
      end
    end else if (keep) begin
      state_q <= StGrant;
      burst_q <= burst_q + BurstW'(1);
      wait_q  <= '0;
    end else if (state_q == StGrant) begin
      // Only reachable for a live device access with a non-zero wait.
      state_q <= StDevWait;
      wait_q  <= WaitLoad;
    end else begin
      wait_q <= wait_q - WaitW'(1);
    end
  end

  assign grant_oh = grant_oh_q;
  assign grant_id = grant_id_q;
  assign ack_oh   = complete ? grant_oh_q : '0;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler: per-cycle expectations are queued by the driver and
// compared by a negedge monitor.
module tb_mem_scheduler;

  logic       clk;
  logic       reset;
  logic [7:0] request;
  logic [7:0] lock;
  logic       device_sel;
  logic [7:0] grant_oh;
  logic [2:0] grant_id;
  logic [7:0] ack_oh;
  logic       busy;

  mem_scheduler #(
    .NUM_REQ    (8),
    .LOCK_MAX   (4),
    .DEVICE_WAIT(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .lock      (lock),
    .device_sel(device_sel),
    .grant_oh  (grant_oh),
    .grant_id  (grant_id),
    .ack_oh    (ack_oh),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] g;
    logic [2:0] id;
    logic [7:0] a;
    logic       b;
    int         n;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_step = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [7:0] rq, input logic [7:0] lk,
                      input logic dv, input logic [7:0] eg, input logic [2:0] eid,
                      input logic [7:0] ea, input logic eb);
    exp_t x;
    #1;
    reset      = rst;
    request    = rq;
    lock       = lk;
    device_sel = dv;
    x.g  = eg;
    x.id = eid;
    x.a  = ea;
    x.b  = eb;
    x.n  = n_step;
    sb.push_back(x);
    n_step++;
    @(posedge clk);
  endtask

  task automatic idle_rst();
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
  endtask

  // Constant request/lock: grant ids per cycle packed as nibbles (first id lowest), each acked;
  // then request drops (abandon, no ack) and a reset returns to idle.
  task automatic run_seq(input logic [7:0] rq, input logic [7:0] lk, input logic [63:0] seq,
                         input int n, input int nx);
    int id;
    step(1'b1, rq, lk, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      id = int'(seq[4*i +: 4]);
      step(1'b1, rq, lk, 1'b0, oh(id), 3'(id), oh(id), 1'b1);
    end
    step(1'b1, 8'h00, 8'h00, 1'b0, oh(nx), 3'(nx), 8'h00, 1'b1);
    idle_rst();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val($sformatf("grant_oh@%0d", e.n), 32'(grant_oh), 32'(e.g));
      check_val($sformatf("grant_id@%0d", e.n), 32'(grant_id), 32'(e.id));
      check_val($sformatf("ack_oh@%0d", e.n), 32'(ack_oh), 32'(e.a));
      check_val($sformatf("busy@%0d", e.n), 32'(busy), 32'(e.b));
      check_val($sformatf("ack_in_grant@%0d", e.n), 32'(ack_oh & ~grant_oh), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog n_step=%0d exp=done", n_step);
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    request    = 8'h00;
    lock       = 8'h00;
    device_sel = 1'b0;
    repeat (2) @(posedge clk);
    idle_rst();

    // Single requester, held: grant and ack every cycle.
    run_seq(8'h08, 8'h00, 64'h333, 3, 3);
    // All requesting, no lock: 0..7 then wrap to 0.
    run_seq(8'hFF, 8'h00, 64'h076543210, 9, 1);
    // Core 2 locked: four grants, then core 5 once, then core 2 again.
    run_seq(8'h24, 8'h04, 64'h222252222, 9, 5);
    // Lock of a non-granted core is ignored until that core is granted.
    run_seq(8'h24, 8'h20, 64'h255552, 6, 5);
    // Lone locked requester keeps being re-granted with no gap.
    run_seq(8'h04, 8'h04, 64'h2222222, 7, 2);

    // Device access: grant held three cycles, ack only in the last; device_sel ignored in wait.
    step(1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 8'h00, 1'b1, 8'h02, 3'd1, 8'h00, 1'b1);
    step(1'b1, 8'h02, 8'h00, 1'b0, 8'h02, 3'd1, 8'h00, 1'b1);
    step(1'b1, 8'h02, 8'h00, 1'b1, 8'h02, 3'd1, 8'h02, 1'b1);
    step(1'b1, 8'h02, 8'h00, 1'b0, 8'h02, 3'd1, 8'h02, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 8'h02, 3'd1, 8'h00, 1'b1);
    idle_rst();

    // Request dropped during device wait, nobody else: no ack, then idle.
    step(1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 8'h00, 1'b1, 8'h02, 3'd1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 8'h02, 3'd1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    idle_rst();

    // Request dropped during device wait, core 2 waiting: grant moves straight to core 2.
    step(1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 8'h00, 1'b1, 8'h02, 3'd1, 8'h00, 1'b1);
    step(1'b1, 8'h04, 8'h00, 1'b0, 8'h02, 3'd1, 8'h00, 1'b1);
    step(1'b1, 8'h04, 8'h00, 1'b0, 8'h04, 3'd2, 8'h04, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h04, 3'd2, 8'h00, 1'b1);
    idle_rst();

    // Reset during device wait aborts with no ack; first grant afterwards goes to core 0.
    step(1'b1, 8'h81, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    step(1'b1, 8'h81, 8'h00, 1'b1, 8'h01, 3'd0, 8'h00, 1'b1);
    step(1'b0, 8'h81, 8'h00, 1'b0, 8'h01, 3'd0, 8'h00, 1'b1);
    step(1'b1, 8'h81, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    step(1'b1, 8'h81, 8'h00, 1'b0, 8'h01, 3'd0, 8'h01, 1'b1);
    step(1'b1, 8'h81, 8'h00, 1'b0, 8'h80, 3'd7, 8'h80, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 8'h01, 3'd0, 8'h00, 1'b1);
    idle_rst();

    @(negedge clk);
    #1;
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
